// File: rtl/calc_ctrl_pkg.sv
// Shared types and constants for the calculator button sequencer: FSM states,
// operation codes, button indices and display geometry.
package calc_ctrl_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int DISP_W     = DIGIT_W * NUM_DIGITS;
  localparam int NUM_BTNS   = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INC,
    ST_START,
    ST_WAIT,
    ST_LOAD
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_ORIG = 3'd4
  } op_e;

  typedef enum int {
    BTN_D1   = 0,
    BTN_D2   = 1,
    BTN_D3   = 2,
    BTN_D4   = 3,
    BTN_ADD  = 4,
    BTN_SUB  = 5,
    BTN_MUL  = 6,
    BTN_DIV  = 7,
    BTN_ORIG = 8
  } btn_idx_e;

  // Index of the lowest set bit; lower-numbered buttons win arbitration.
  function automatic logic [3:0] lowest_btn(input logic [NUM_BTNS-1:0] ev);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (ev[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Handshake between the sequencer (master) and the digit-generator /
// arithmetic datapath (slave).
interface calc_op_sequencer_if;
  import calc_ctrl_pkg::*;

  logic [DISP_W-1:0]     og_digits;
  logic [DISP_W-1:0]     res_digits;
  logic                  op_done;
  logic [NUM_DIGITS-1:0] digit_inc;
  logic [2:0]            op_sel;
  logic                  op_start;

  modport master (
    output digit_inc, op_sel, op_start,
    input  og_digits, res_digits, op_done
  );

  modport slave (
    input  digit_inc, op_sel, op_start,
    output og_digits, res_digits, op_done
  );

endinterface

// File: rtl/btn_debounce.sv
// Single-button debouncer: the accepted level follows the raw level only after
// DEBOUNCE_CYCLES consecutive differing samples; o_rise marks each 0->1 acceptance.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (i_raw == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= i_raw;
        r_rise  <= i_raw;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator button sequencer: debounces nine buttons, arbitrates presses and
// drives the digit/arithmetic units through a start/done handshake.
module calc_op_sequencer
  import calc_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn,
  calc_op_sequencer_if.master dp,
  output logic [DISP_W-1:0]   disp_digits,
  output logic                busy,
  output logic                err
);

  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam int DW = $clog2(NUM_DIGITS);

  logic [NUM_BTNS-1:0] w_level;
  logic [NUM_BTNS-1:0] w_rise;
  logic [NUM_BTNS-1:0] w_ev;
  logic [3:0]          w_win;
  logic                w_accept;
  logic                w_timeout;
  state_e              w_state_next;

  state_e              r_state;
  logic [DW-1:0]       r_digit;
  op_e                 r_op_sel;
  logic                r_load_og;
  logic                r_err;
  logic [DISP_W-1:0]   r_disp;
  logic [TW-1:0]       r_wait_cnt;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_in (clk_in),
      .reset  (reset),
      .i_raw  (btn[g]),
      .o_level(w_level[g]),
      .o_rise (w_rise[g])
    );
  end

  // A rise is honoured only while its accepted level is still high.
  assign w_ev  = w_rise & w_level;
  assign w_win = lowest_btn(w_ev);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_ev) begin
          w_accept     = 1'b1;
          w_state_next = (w_win < 4'(BTN_ADD)) ? ST_INC : ST_START;
        end
      end
      ST_INC:   w_state_next = ST_LOAD;
      ST_START: w_state_next = ST_WAIT;
      ST_WAIT: begin
        // The counter runs 0..TIMEOUT_CYCLES; a done in the final cycle still wins.
        if (dp.op_done) begin
          w_state_next = ST_LOAD;
        end else if (r_wait_cnt == TW'(TIMEOUT_CYCLES)) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_LOAD:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_digit    <= '0;
      r_op_sel   <= OP_ADD;
      r_load_og  <= 1'b0;
      r_err      <= 1'b0;
      r_disp     <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_err <= 1'b0;
        if (w_win < 4'(BTN_ADD)) begin
          r_digit   <= w_win[DW-1:0];
          r_load_og <= 1'b1;
        end else begin
          r_op_sel  <= op_e'(3'(w_win - 4'(BTN_ADD)));
          r_load_og <= 1'b0;
        end
      end
      if (w_timeout) r_err <= 1'b1;
      if (r_state == ST_START) begin
        r_wait_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (r_state == ST_LOAD) begin
        r_disp <= r_load_og ? dp.og_digits : dp.res_digits;
      end
    end
  end

  always_comb begin
    dp.digit_inc = '0;
    dp.op_start  = 1'b0;
    if (r_state == ST_INC)   dp.digit_inc = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_digit;
    if (r_state == ST_START) dp.op_start  = 1'b1;
  end

  assign dp.op_sel   = r_op_sel;
  assign busy        = (r_state != ST_IDLE);
  assign err         = r_err;
  assign disp_digits = r_disp;

endmodule
